// File: rtl/mips_isa_pkg.sv
// Shared ISA constants, instruction field helpers
// and the fetch FSM state type.
package mips_isa_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'b000001;
    localparam logic [5:0]  OP_SW    = 6'b000011;
    localparam logic [5:0]  OP_HALT  = 6'b111111;
    localparam logic [31:0] NOP_WORD = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HALT
    } fetch_state_e;

    function automatic logic [5:0] f_opcode(input logic [31:0] w);
        return w[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] w);
        return w[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] w);
        return w[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] w);
        return w[15:11];
    endfunction

    function automatic logic [4:0] f_shamt(input logic [31:0] w);
        return w[10:6];
    endfunction

    function automatic logic [5:0] f_funct(input logic [31:0] w);
        return w[5:0];
    endfunction

endpackage

// File: rtl/instr_rom.sv
// Single-port instruction store: synchronous write,
// synchronous read with read enable. Contents are never reset.
module instr_rom #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Write port and registered read share the one address.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, store read stage and output register,
// with stall, redirect squash and HALT detection.
module instr_fetch
    import mips_isa_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              run,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       instruction_memory,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              halted,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              rd_vld_q, rd_vld_d;
    logic [ADDR_W-1:0] rd_pc_q, rd_pc_d;
    logic [31:0]       out_word_q, out_word_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              out_vld_q, out_vld_d;
    logic              halted_q, halted_d;

    logic              fetching;
    logic              halt_hit;
    logic              rom_we;
    logic              rom_re;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_rdata;

    assign fetching = (state_q == ST_FETCH);
    assign halt_hit = fetching && out_vld_q && !stall
                   && !redirect_valid
                   && (f_opcode(out_word_q) == OP_HALT);

    // Redirect target bypasses the PC so the squash costs one bubble.
    assign rom_addr = !fetching      ? load_addr
                    : redirect_valid ? redirect_pc
                    : pc_q;
    assign rom_we   = load_en && !fetching;
    assign rom_re   = fetching && (redirect_valid || !stall);

    instr_rom #(
        .ADDR_W (ADDR_W)
    ) u_rom (
        .clk_i   (clk),
        .we_i    (rom_we),
        .re_i    (rom_re),
        .addr_i  (rom_addr),
        .wdata_i (load_data),
        .rdata_o (rom_rdata)
    );

    // Next state: run start, redirect, HALT retire, advance.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rd_vld_d   = rd_vld_q;
        rd_pc_d    = rd_pc_q;
        out_word_d = out_word_q;
        out_pc_d   = out_pc_q;
        out_vld_d  = out_vld_q;
        halted_d   = halted_q;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (run) begin
                    state_d   = ST_FETCH;
                    pc_d      = RST_PC;
                    rd_vld_d  = 1'b0;
                    out_vld_d = 1'b0;
                    halted_d  = 1'b0;
                end
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_d      = redirect_pc + ONE;
                    rd_vld_d  = 1'b1;
                    rd_pc_d   = redirect_pc;
                    out_vld_d = 1'b0;
                end else if (halt_hit) begin
                    state_d   = ST_HALT;
                    halted_d  = 1'b1;
                    rd_vld_d  = 1'b0;
                    out_vld_d = 1'b0;
                end else if (!stall) begin
                    pc_d       = pc_q + ONE;
                    rd_vld_d   = 1'b1;
                    rd_pc_d    = pc_q;
                    out_vld_d  = rd_vld_q;
                    out_word_d = rom_rdata;
                    out_pc_d   = rd_pc_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RST_PC;
            rd_vld_q   <= 1'b0;
            rd_pc_q    <= '0;
            out_word_q <= NOP_WORD;
            out_pc_q   <= '0;
            out_vld_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rd_vld_q   <= rd_vld_d;
            rd_pc_q    <= rd_pc_d;
            out_word_q <= out_word_d;
            out_pc_q   <= out_pc_d;
            out_vld_q  <= out_vld_d;
            halted_q   <= halted_d;
        end
    end

    assign instruction_memory = out_vld_q ? out_word_q : NOP_WORD;
    assign instr_pc           = out_pc_q;
    assign instr_valid        = out_vld_q;
    assign halted             = halted_q;
    assign busy               = fetching;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed programs,
// randomized stall/redirect runs and a 2-bit wrap instance.
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        run = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic [31:0] instruction_memory;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        halted;
    logic        busy;

    logic        l2_en = 1'b0;
    logic [1:0]  l2_addr = '0;
    logic [31:0] l2_data = '0;
    logic        run2 = 1'b0;
    logic        stall2 = 1'b0;
    logic        redir2 = 1'b0;
    logic [1:0]  redir2_pc = '0;
    logic [31:0] word2;
    logic [1:0]  pc2;
    logic        valid2;
    logic        halted2;
    logic        busy2;

    instr_fetch #(.ADDR_W(8), .RESET_PC(0)) u_dut (
        .clk (clk), .rst (rst),
        .load_en (load_en), .load_addr (load_addr),
        .load_data (load_data), .run (run), .stall (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc (redirect_pc),
        .instruction_memory (instruction_memory),
        .instr_pc (instr_pc), .instr_valid (instr_valid),
        .halted (halted), .busy (busy)
    );

    instr_fetch #(.ADDR_W(2), .RESET_PC(0)) u_dut2 (
        .clk (clk), .rst (rst),
        .load_en (l2_en), .load_addr (l2_addr),
        .load_data (l2_data), .run (run2), .stall (stall2),
        .redirect_valid (redir2), .redirect_pc (redir2_pc),
        .instruction_memory (word2), .instr_pc (pc2),
        .instr_valid (valid2), .halted (halted2), .busy (busy2)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    // ---------------- reference model + monitor (dut1)
    logic [31:0] mem_m [256];
    logic [7:0]  q[$];
    bit          running = 0;
    bit f_rst = 0, f_bub = 0, f_halt = 0, f_gap = 0, f_hold = 0;
    logic [7:0]  e;
    logic [31:0] w;
    bit          have;

    always @(negedge clk) begin
        if (f_rst) begin
            check("rst_word", instruction_memory, 32'h0);
            check("rst_pc", {24'h0, instr_pc}, 32'h0);
            check("rst_valid", {31'h0, instr_valid}, 32'h0);
            check("rst_halted", {31'h0, halted}, 32'h0);
            check("rst_busy", {31'h0, busy}, 32'h0);
        end
        if (f_bub) check("redir_bubble", {31'h0, instr_valid}, 32'h0);
        if (f_halt) begin
            check("halt_valid", {31'h0, instr_valid}, 32'h0);
            check("halt_flag", {31'h0, halted}, 32'h1);
            check("halt_busy", {31'h0, busy}, 32'h0);
        end
        if (f_gap) check("no_gap", {31'h0, instr_valid}, 32'h1);
        if (f_hold) check("stall_hold", {31'h0, instr_valid}, 32'h1);
        if (instr_valid === 1'b0)
            check("nop_bubble", instruction_memory, 32'h0);
        f_rst = 0; f_bub = 0; f_halt = 0; f_gap = 0; f_hold = 0;
        have = 0;
        if (rst) begin
            q.delete();
            running = 0;
            f_rst = 1;
        end else if (running) begin
            if (instr_valid) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL sb_extra: got pc %h, want none",
                             instr_pc);
                end else begin
                    e = q[0];
                    w = mem_m[e];
                    have = 1;
                    check("sb_pc", {24'h0, instr_pc}, {24'h0, e});
                    check("sb_word", instruction_memory, w);
                    if (!stall) void'(q.pop_front());
                end
            end
            if (redirect_valid) begin
                q.delete();
                q.push_back(redirect_pc);
                f_bub = 1;
            end else if (have && !stall) begin
                if (w[31:26] == 6'h3f) begin
                    running = 0;
                    f_halt = 1;
                end else begin
                    q.push_back(e + 8'd1);
                    f_gap = 1;
                end
            end else if (have) begin
                f_hold = 1;
            end
        end else begin
            if (load_en) mem_m[load_addr] = load_data;
            if (run) begin
                q.delete();
                q.push_back(8'h00);
                running = 1;
            end
        end
    end

    // ---------------- wrap instance monitor (dut2)
    logic [31:0] mem2 [4];
    logic [1:0]  q2[$];
    bit          started2 = 0;
    logic [1:0]  e2;

    always @(negedge clk) begin
        if (q2.size() > 0 && (valid2 || started2)) begin
            started2 = 1;
            check("wrap_valid", {31'h0, valid2}, 32'h1);
            if (valid2) begin
                e2 = q2.pop_front();
                check("wrap_pc", {30'h0, pc2}, {30'h0, e2});
                check("wrap_word", word2, mem2[e2]);
            end
        end
    end

    // ---------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        load_en = 1; load_addr = a; load_data = d;
        tick();
        load_en = 0;
    endtask

    task automatic pulse_run();
        run = 1;
        tick();
        run = 0;
    endtask

    task automatic wait_halt(input string nm, input int bound);
        int n;
        n = 0;
        while (!halted && n < bound) begin
            tick();
            n++;
        end
        if (!halted) begin
            total++;
            $display("FAIL %s: no halt after %0d cycles", nm, bound);
        end
    endtask

    task automatic wait_pc(input string nm, input logic [7:0] p);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(instr_valid && instr_pc == p) && n < 50);
        if (!(instr_valid && instr_pc == p)) begin
            total++;
            $display("FAIL %s: pc %h not shown, want %h", nm, instr_pc, p);
        end
    endtask

    logic [31:0] prog [5];
    logic [31:0] rw;
    int          len;

    initial begin
        prog[0] = 32'h04224032;
        prog[1] = 32'h04644820;
        prog[2] = 32'h05095022;
        prog[3] = 32'h0CCA0000;
        prog[4] = 32'hFC000000;
        repeat (3) tick();
        rst = 0;
        tick();

        // wrap-around on the 4-word instance
        for (int i = 0; i < 4; i++) begin
            mem2[i] = 32'h0400_0000 | 32'(i * 17 + 3);
            l2_en = 1; l2_addr = 2'(i); l2_data = mem2[i];
            tick();
        end
        l2_en = 0;
        q2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        run2 = 1; tick(); run2 = 0;
        for (int n = 0; n < 40 && q2.size() > 0; n++) tick();
        if (q2.size() > 0) begin
            total++;
            $display("FAIL wrap_timeout: %0d left, want 0", q2.size());
        end

        // straight program
        for (int i = 0; i < 5; i++) load(8'(i), prog[i]);
        pulse_run();
        wait_halt("t1_halt", 50);

        // stall on add
        pulse_run();
        wait_pc("t2_wait", 8'd1);
        stall = 1;
        repeat (3) tick();
        stall = 0;
        wait_halt("t2_halt", 50);

        // redirect on mul
        pulse_run();
        wait_pc("t3_wait", 8'd0);
        redirect_valid = 1; redirect_pc = 8'd3;
        tick();
        redirect_valid = 0;
        wait_halt("t3_halt", 50);

        // redirect beats stall
        pulse_run();
        wait_pc("t4_wait", 8'd1);
        stall = 1; redirect_valid = 1; redirect_pc = 8'd0;
        tick();
        stall = 0; redirect_valid = 0;
        wait_halt("t4_halt", 50);

        // reset mid-fetch, store retained, load ignored in FETCH
        pulse_run();
        wait_pc("t6_wait", 8'd1);
        load(8'd0, 32'hDEADBEEF);
        rst = 1;
        tick();
        rst = 0;
        tick();
        pulse_run();
        wait_halt("t6_halt", 50);

        // randomized programs with random stall/redirect
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(5, 12);
            for (int i = 0; i < len - 1; i++) begin
                rw = $urandom;
                if (rw[31:26] == 6'h3f) rw[31:26] = 6'h01;
                load(8'(i), rw);
            end
            load(8'(len - 1), 32'hFC000000 | 32'($urandom_range(0, 255)));
            pulse_run();
            for (int n = 0; n < 2000 && !halted; n++) begin
                stall = ($urandom_range(0, 99) < 30);
                redirect_valid = ($urandom_range(0, 99) < 8);
                redirect_pc = 8'($urandom_range(0, len - 1));
                tick();
            end
            stall = 0; redirect_valid = 0;
            if (!halted) begin
                total++;
                $display("FAIL rand_halt: run %0d did not halt", r);
            end
            tick();
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
